// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: show-ahead byte FIFO, idle-timeout detector,
// sticky overrun/timeout flags and a registered interrupt request.
module uart_rx_ctrl #(
    parameter int DEPTH    = 8,
    parameter int TO_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     b_tick,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    input  logic [$clog2(DEPTH):0]   thresh,
    input  logic [2:0]               ie,
    input  logic                     clr_ovr,
    input  logic                     clr_to,
    output logic                     overrun,
    output logic                     timeout,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TO_TICKS);

    localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL_C = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
    localparam logic [TW-1:0] TCNT_ZERO_C = {TW{1'b0}};
    localparam logic [TW-1:0] TCNT_ONE_C  = TW'(1);
    localparam logic [TW-1:0] TCNT_LAST_C = TW'(TO_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          irq_q, irq_d;
    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [CW-1:0] eff_thresh_s;
    logic          do_rd_s, do_wr_s, ovr_set_s, to_set_s;

    // FIFO access decode, pointer/occupancy update and next show-ahead head
    always_comb begin
        do_rd_s   = rd_en && (count_q != CNT_ZERO_C);
        // when full, a same-cycle pop frees the slot the write is about to use
        do_wr_s   = rx_done && ((count_q != CNT_FULL_C) || rd_en);
        ovr_set_s = rx_done && (count_q == CNT_FULL_C) && !rd_en;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + (do_wr_s ? CNT_ONE_C : CNT_ZERO_C)
                          - (do_rd_s ? CNT_ONE_C : CNT_ZERO_C);
        empty_d = (count_d == CNT_ZERO_C);
        full_d  = (count_d == CNT_FULL_C);
        // the new head may be the byte being written this very cycle
        if (count_d == CNT_ZERO_C) begin
            rd_data_d = 8'h00;
        end else if (do_wr_s && (rd_ptr_d == wr_ptr_q)) begin
            rd_data_d = rx_data;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    // Idle-timeout state machine next state
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        to_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (do_wr_s) begin
                    state_d = ST_ARMED;
                    tcnt_d  = TCNT_ZERO_C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (count_d == CNT_ZERO_C) begin
                    state_d = ST_IDLE;
                    tcnt_d  = TCNT_ZERO_C;
                end else if (do_wr_s || do_rd_s) begin
                    tcnt_d = TCNT_ZERO_C;
                end else if (b_tick) begin
                    if (tcnt_q == TCNT_LAST_C) begin
                        state_d  = ST_EXPIRED;
                        to_set_s = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_ONE_C;
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            ST_EXPIRED: begin
                if (count_d == CNT_ZERO_C) begin
                    state_d = ST_IDLE;
                    tcnt_d  = TCNT_ZERO_C;
                end else if (do_wr_s || do_rd_s) begin
                    state_d = ST_ARMED;
                    tcnt_d  = TCNT_ZERO_C;
                end else begin
                    state_d = ST_EXPIRED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = TCNT_ZERO_C;
            end
        endcase
    end

    // Sticky flags (set beats clear), threshold clamping and interrupt request
    always_comb begin
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (to_set_s) begin
            timeout_d = 1'b1;
        end else if (clr_to) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
        if (thresh == CNT_ZERO_C) begin
            eff_thresh_s = CNT_ONE_C;
        end else if (thresh > CNT_FULL_C) begin
            eff_thresh_s = CNT_FULL_C;
        end else begin
            eff_thresh_s = thresh;
        end
        irq_d = (ie[0] && (count_q >= eff_thresh_s)) ||
                (ie[1] && timeout_q) ||
                (ie[2] && overrun_q);
    end

    // Byte storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (do_wr_s && !reset) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= CNT_ZERO_C;
            rd_data_q <= 8'h00;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
            state_q   <= ST_IDLE;
            tcnt_q    <= TCNT_ZERO_C;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;
    assign empty   = empty_q;
    assign full    = full_q;
    assign overrun = overrun_q;
    assign timeout = timeout_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH    = 8;
    localparam int TO_TICKS = 640;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       b_tick = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic       empty, full;
    logic [3:0] thresh = 4'd1;
    logic [2:0] ie = 3'b000;
    logic       clr_ovr = 1'b0, clr_to = 1'b0;
    logic       overrun, timeout, irq;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int m_q[$];
    int m_since = 0;
    bit m_expired = 1'b0;
    bit m_ovr = 1'b0, m_to = 1'b0, m_irq = 1'b0;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TO_TICKS(TO_TICKS)) dut (
        .clk(clk), .reset(reset), .b_tick(b_tick), .rx_done(rx_done),
        .rx_data(rx_data), .rd_en(rd_en), .rd_data(rd_data), .count(count),
        .empty(empty), .full(full), .thresh(thresh), .ie(ie),
        .clr_ovr(clr_ovr), .clr_to(clr_to), .overrun(overrun),
        .timeout(timeout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  sz, eff;
        bit  rd, wr, ovr_ev, to_ev;
        if (reset) begin
            m_q.delete();
            m_since = 0; m_expired = 1'b0;
            m_ovr = 1'b0; m_to = 1'b0; m_irq = 1'b0;
        end else begin
            sz  = m_q.size();
            eff = (thresh == 4'd0) ? 1 : ((int'(thresh) > DEPTH) ? DEPTH : int'(thresh));
            m_irq = (ie[0] && sz >= eff) || (ie[1] && m_to) || (ie[2] && m_ovr);
            rd     = rd_en && sz > 0;
            wr     = rx_done && (sz < DEPTH || rd_en);
            ovr_ev = rx_done && sz == DEPTH && !rd_en;
            to_ev  = 1'b0;
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(int'(rx_data));
            if (m_q.size() == 0 || wr || rd) begin
                m_since = 0; m_expired = 1'b0;
            end else if (!m_expired && b_tick) begin
                m_since++;
                if (m_since == TO_TICKS) begin
                    m_expired = 1'b1; to_ev = 1'b1;
                end
            end
            m_ovr = ovr_ev ? 1'b1 : (clr_ovr ? 1'b0 : m_ovr);
            m_to  = to_ev  ? 1'b1 : (clr_to  ? 1'b0 : m_to);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        chk("count",   32'(count),   32'(sz));
        chk("empty",   32'(empty),   32'(sz == 0));
        chk("full",    32'(full),    32'(sz == DEPTH));
        chk("rd_data", 32'(rd_data), (sz == 0) ? 32'd0 : 32'(m_q[0]));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("irq",     32'(irq),     32'(m_irq));
    endtask

    task automatic cyc(input bit rst, input bit rxd, input logic [7:0] d,
                       input bit rd, input bit tk, input bit co, input bit ct);
        reset = rst; rx_done = rxd; rx_data = d; rd_en = rd;
        b_tick = tk; clr_ovr = co; clr_to = ct;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 1'b0; rx_done = 1'b0; rd_en = 1'b0;
        b_tick = 1'b0; clr_ovr = 1'b0; clr_to = 1'b0;
        check_all();
    endtask

    task automatic wr(input logic [7:0] d); cyc(0, 1, d, 0, 0, 0, 0); endtask
    task automatic pop();                   cyc(0, 0, 8'h00, 1, 0, 0, 0); endtask
    task automatic idle();                  cyc(0, 0, 8'h00, 0, 0, 0, 0); endtask

    initial begin
        // reset state
        cyc(1, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);

        // in-order write/read of three bytes
        wr(8'h41); wr(8'h42); wr(8'h43);
        chk("fifo3_count", 32'(count), 32'd3);
        chk("fifo3_head0", 32'(rd_data), 32'h41);
        pop(); chk("fifo3_head1", 32'(rd_data), 32'h42); chk("fifo3_c2", 32'(count), 32'd2);
        pop(); chk("fifo3_head2", 32'(rd_data), 32'h43); chk("fifo3_c1", 32'(count), 32'd1);
        pop(); chk("fifo3_c0", 32'(count), 32'd0); chk("fifo3_empty", 32'(empty), 32'd1);
        // pop on empty and write+pop on empty
        pop(); chk("pop_empty_count", 32'(count), 32'd0);
        cyc(0, 1, 8'h77, 1, 0, 0, 0);
        chk("wr_rd_empty_count", 32'(count), 32'd1);
        chk("wr_rd_empty_head", 32'(rd_data), 32'h77);
        pop();

        // overrun on full FIFO
        for (int i = 0; i < DEPTH; i++) wr(8'(8'h60 + i));
        cyc(0, 1, 8'h99, 0, 0, 0, 0);
        chk("ovr_count", 32'(count), 32'd8);
        chk("ovr_full", 32'(full), 32'd1);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_head", 32'(rd_data), 32'h60);
        cyc(0, 0, 8'h00, 0, 0, 1, 0);
        chk("ovr_clr", 32'(overrun), 32'd0);

        // write with pop on full FIFO
        cyc(0, 1, 8'h55, 1, 0, 0, 0);
        chk("fullrw_count", 32'(count), 32'd8);
        chk("fullrw_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 7; i++) pop();
        chk("fullrw_last", 32'(rd_data), 32'h55);
        chk("fullrw_c1", 32'(count), 32'd1);
        pop();

        // idle timeout
        ie = 3'b010;
        wr(8'hA5);
        for (int i = 0; i < TO_TICKS - 1; i++) cyc(0, 0, 8'h00, 0, 1, 0, 0);
        chk("to_before", 32'(timeout), 32'd0);
        cyc(0, 0, 8'h00, 0, 1, 0, 0);
        chk("to_set", 32'(timeout), 32'd1);
        idle();
        chk("to_irq", 32'(irq), 32'd1);
        pop();
        chk("to_sticky", 32'(timeout), 32'd1);
        cyc(0, 0, 8'h00, 0, 1, 0, 1);
        chk("to_clr", 32'(timeout), 32'd0);
        idle();

        // level interrupt, including threshold clamping
        ie = 3'b001; thresh = 4'd4;
        wr(8'h01); wr(8'h02); wr(8'h03); idle();
        chk("lvl_3", 32'(irq), 32'd0);
        wr(8'h04); idle();
        chk("lvl_4", 32'(irq), 32'd1);
        pop(); idle();
        chk("lvl_pop", 32'(irq), 32'd0);
        thresh = 4'd0; idle(); idle();
        chk("lvl_th0", 32'(irq), 32'd1);
        thresh = 4'd15; idle(); idle();
        chk("lvl_th15", 32'(irq), 32'd0);
        ie = 3'b000; thresh = 4'd1;

        // reset mid-operation with 5 bytes stored and overrun set
        for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
        cyc(0, 1, 8'h99, 0, 0, 0, 0);
        pop(); pop(); pop();
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_ovr", 32'(overrun), 32'd1);
        cyc(1, 1, 8'hEE, 1, 1, 0, 0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_rd", 32'(rd_data), 32'd0);
        wr(8'h10);
        chk("post_rst_head", 32'(rd_data), 32'h10);
        chk("post_rst_count", 32'(count), 32'd1);

        // dense random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                thresh = 4'($urandom_range(15, 0));
                ie     = 3'($urandom_range(7, 0));
            end
            cyc(($urandom_range(299, 0) == 0), ($urandom_range(2, 0) == 0),
                8'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
                ($urandom_range(19, 0) == 0), ($urandom_range(19, 0) == 0));
        end
        // sparse traffic with a tick every cycle to exercise timeouts
        for (int i = 0; i < 5000; i++) begin
            cyc(1'b0, ($urandom_range(799, 0) == 0), 8'($urandom),
                ($urandom_range(999, 0) == 0), 1'b1,
                ($urandom_range(499, 0) == 0), ($urandom_range(499, 0) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
